// File: rtl/icache_refill_if.sv
// ----------------------------------------------------------------------------
// icache_refill_if
// Wishbone B4 classic/burst read port used by the instruction-cache refill
// engine.
//   master : refill engine side (drives cyc/stb/adr/cti/..., receives
//            ack/err/rty and read data)
//   slave  : memory side
// ----------------------------------------------------------------------------
interface icache_refill_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [1:0]  wb_bte_o;
    logic [2:0]  wb_cti_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic [31:0] wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_bte_o, wb_cti_o,
               wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_bte_o, wb_cti_o,
               wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
endinterface

// File: rtl/icache_refill.sv
// ----------------------------------------------------------------------------
// icache_refill
// Line-refill engine for the instruction cache. On a miss it fetches one
// 32-byte line over a Wishbone incrementing burst, assembles the 256-bit
// line, presents it with a one-cycle write strobe and keeps the fetch
// pipeline frozen until the cache's two-cycle write has finished.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous reset, active HIGH despite the name
//   miss_req   : cache miss, sampled only while idle
//   miss_addr  : fetch address, bits [4:0] ignored
//   wr_data    : assembled line, word k at [32k+31:32k]
//   we         : one-cycle line write strobe
//   freeze     : pipeline stall while a refill is in progress
//   refill_err : one-cycle pulse when a refill is aborted
//   wb         : Wishbone master port (icache_refill_if.master)
//
// Optional feature: define ICACHE_REFILL_TIMEOUT_EN to abort a burst after
// TIMEOUT_CYCLES consecutive cycles without any slave termination.
//
// State      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for miss_req
// S_BURST    | beat cnt issued on the bus (cyc=stb=1)
// S_RETRY    | one-cycle stb gap after wb_rty_i, then re-issue same beat
// S_WRITE    | line presented, we=1
// S_SETTLE   | cache completing the way write, freeze still high
// ----------------------------------------------------------------------------
module icache_refill #(
    parameter int LINE_WORDS     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_req,
    input  logic [31:0]              miss_addr,
    output logic [LINE_WORDS*32-1:0] wr_data,
    output logic                     we,
    output logic                     freeze,
    output logic                     refill_err,
    icache_refill_if.master          wb
);
    localparam int            CW   = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BURST,
        S_RETRY,
        S_WRITE,
        S_SETTLE
    } state_t;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [31:0]                       base_q, base_d;
    logic [LINE_WORDS-1:0][31:0]       line_q, line_d;
    logic                              we_q, we_d;
    logic                              freeze_q, freeze_d;
    logic                              err_q, err_d;
    logic                              cyc_q, cyc_d;
    logic                              stb_q, stb_d;
    logic [31:0]                       adr_q, adr_d;
    logic [2:0]                        cti_q, cti_d;
    logic                              tmo_hit;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy, any_term;

    // Counts consecutive bus cycles without any termination; a RETRY cycle
    // never carries a response so it counts too.
    always_comb begin
        busy     = (state_q == S_BURST) || (state_q == S_RETRY);
        any_term = (state_q == S_BURST) && (wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i);
        tmo_d    = '0;
        tmo_hit  = 1'b0;
        if (busy && !any_term) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        line_d  = line_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    base_d  = miss_addr & 32'hFFFF_FFE0;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                // err beats ack beats rty; a timeout behaves like err.
                if (wb.wb_err_i || tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (wb.wb_ack_i) begin
                    line_d[cnt_q] = wb.wb_dat_i;
                    cnt_d         = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = S_WRITE;
                    end
                end else if (wb.wb_rty_i) begin
                    state_d = S_RETRY;
                end
            end
            S_RETRY: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BURST;
                end
            end
            S_WRITE:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        we_d     = (state_d == S_WRITE);
        freeze_d = (state_d != S_IDLE);
        cyc_d    = (state_d == S_BURST) || (state_d == S_RETRY);
        stb_d    = (state_d == S_BURST);
        adr_d    = cyc_d ? base_d + {{(30 - CW){1'b0}}, cnt_d, 2'b00} : 32'h0;
        cti_d    = stb_d ? ((cnt_d == LAST) ? 3'b111 : 3'b010) : 3'b000;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            line_q   <= '0;
            we_q     <= 1'b0;
            freeze_q <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            adr_q    <= '0;
            cti_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            line_q   <= line_d;
            we_q     <= we_d;
            freeze_q <= freeze_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            adr_q    <= adr_d;
            cti_q    <= cti_d;
        end
    end

    assign wr_data     = line_q;
    assign we          = we_q;
    assign freeze      = freeze_q;
    assign refill_err  = err_q;

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_bte_o = 2'b00;
    assign wb.wb_sel_o = 4'hF;
    assign wb.wb_dat_o = 32'h0;
endmodule

// File: tb/tb_icache_refill.sv
// ----------------------------------------------------------------------------
// tb_icache_refill
// Scoreboard bench for icache_refill. Each refill queues the expected bus
// beats (address + cycle type), the slave's responses, and the expected
// outcome (finished line or abort with the partial line). A slave process
// plays the responses; a monitor process pops and compares whenever the DUT
// completes a beat, strobes we or pulses refill_err.
// ----------------------------------------------------------------------------
module tb_icache_refill;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = 32'h0;
    logic [255:0] wr_data;
    logic         we, freeze, refill_err;

    icache_refill_if wb ();

    icache_refill #(.LINE_WORDS(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .wr_data    (wr_data),
        .we         (we),
        .freeze     (freeze),
        .refill_err (refill_err),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] adr; logic [2:0] cti; } beat_t;
    typedef struct { bit is_err; logic [255:0] line; } out_t;
    typedef struct { int wait_cyc; bit ack; bit err; bit rty; logic [31:0] data; } resp_t;

    beat_t        exp_beats[$];
    out_t         outcomes[$];
    resp_t        plan[$];
    logic [255:0] model_line = '0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_we  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a line is 8 words at base+4k; the last beat is an
    // end-of-burst cycle; every slave wait adds a cycle, a retry adds the
    // retried attempt plus a one-cycle gap; WRITE and SETTLE add two.
    task automatic queue_txn(input logic [31:0] addr, input bit rand_data, input logic [31:0] seed,
                             input int minw, input int maxw, input int rty_beat,
                             input int err_beat, input bit err_ack, output int exp_cyc);
        logic [31:0] base;
        logic [31:0] d;
        resp_t       r;
        out_t        o;
        beat_t       b;
        int          w;
        base    = addr & 32'hFFFF_FFE0;
        exp_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            b.adr = base + 32'(4 * k);
            b.cti = (k == 7) ? 3'b111 : 3'b010;
            d     = rand_data ? $urandom : seed + 32'(k);
            if (k == err_beat) begin
                w = $urandom_range(maxw, minw);
                exp_beats.push_back(b);
                r.wait_cyc = w; r.ack = err_ack; r.err = 1'b1;
                r.rty = 1'($urandom_range(1, 0)); r.data = d;
                plan.push_back(r);
                exp_cyc += 1 + w;
                o.is_err = 1'b1; o.line = model_line;
                outcomes.push_back(o);
                return;
            end
            if (k == rty_beat) begin
                w = $urandom_range(maxw, minw);
                exp_beats.push_back(b);
                r.wait_cyc = w; r.ack = 1'b0; r.err = 1'b0; r.rty = 1'b1; r.data = $urandom;
                plan.push_back(r);
                exp_cyc += 2 + w;
            end
            w = $urandom_range(maxw, minw);
            exp_beats.push_back(b);
            r.wait_cyc = w; r.ack = 1'b1; r.err = 1'b0; r.rty = 1'b0; r.data = d;
            plan.push_back(r);
            model_line[32 * k +: 32] = d;
            exp_cyc += 1 + w;
        end
        exp_cyc += 2;
        o.is_err = 1'b0; o.line = model_line;
        outcomes.push_back(o);
    endtask

    task automatic run_txn(input logic [31:0] addr, input bit rand_data, input logic [31:0] seed,
                           input int minw, input int maxw, input int rty_beat,
                           input int err_beat, input bit err_ack);
        int exp_cyc, got, we_at, we_cnt, gap, n_rty;
        bit is_err, done, err_seen;
        is_err = (err_beat >= 0 && err_beat < 8);
        n_rty  = (rty_beat >= 0 && rty_beat < 8 && (!is_err || rty_beat < err_beat)) ? 1 : 0;
        queue_txn(addr, rand_data, seed, minw, maxw, rty_beat, err_beat, err_ack, exp_cyc);
        @(posedge clk); #1;
        miss_req  = 1'b1;
        miss_addr = addr;
        @(posedge clk); #1;
        miss_req  = 1'b0;
        got = 0; we_at = -1; we_cnt = 0; gap = 0; done = 1'b0; err_seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!freeze) begin
                done     = 1'b1;
                err_seen = refill_err;
                break;
            end
            got++;
            if (we) begin we_at = i; we_cnt++; end
            if (wb.wb_cyc_o && !wb.wb_stb_o) gap++;
        end
        chk("refill_finished", 256'(done), 256'(1));
        chk("freeze_cycles", 256'(got), 256'(exp_cyc));
        chk("we_pulse_count", 256'(we_cnt), is_err ? 256'(0) : 256'(1));
        if (!is_err) chk("we_cycle_after_request", 256'(we_at + 1), 256'(exp_cyc - 1));
        chk("retry_gap_cycles", 256'(gap), 256'(n_rty));
        chk("refill_err_at_end", 256'(err_seen), 256'(is_err));
        @(negedge clk);
        chk("idle_after_refill", {253'b0, refill_err, we, freeze}, 256'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_data"}, wr_data, 256'(0));
        chk({tag, "_we"}, 256'(we), 256'(0));
        chk({tag, "_freeze"}, 256'(freeze), 256'(0));
        chk({tag, "_refill_err"}, 256'(refill_err), 256'(0));
        chk({tag, "_cyc"}, 256'(wb.wb_cyc_o), 256'(0));
        chk({tag, "_stb"}, 256'(wb.wb_stb_o), 256'(0));
        chk({tag, "_adr"}, 256'(wb.wb_adr_o), 256'(0));
        chk({tag, "_cti"}, 256'(wb.wb_cti_o), 256'(0));
    endtask

    task automatic flush_model();
        exp_beats.delete();
        outcomes.delete();
        plan.delete();
        model_line = '0;
    endtask

    // Slave: responds one cycle after seeing stb, after the planned waits.
    initial begin
        resp_t p;
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0; wb.wb_dat_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
            if (!rst_n && wb.wb_cyc_o && wb.wb_stb_o && plan.size() > 0) begin
                if (plan[0].wait_cyc > 0) begin
                    plan[0].wait_cyc = plan[0].wait_cyc - 1;
                end else begin
                    p = plan.pop_front();
                    wb.wb_ack_i = p.ack;
                    wb.wb_err_i = p.err;
                    wb.wb_rty_i = p.rty;
                    wb.wb_dat_i = p.data;
                end
            end
        end
    end

    // Monitor
    initial begin
        beat_t b;
        out_t  o;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (wb.wb_stb_o && (wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i)) begin
                    if (exp_beats.size() == 0) begin
                        chk("unexpected_beat", 256'(wb.wb_adr_o), 256'(0) - 256'(1));
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_adr", 256'(wb.wb_adr_o), 256'(b.adr));
                        chk("beat_cti", 256'(wb.wb_cti_o), 256'(b.cti));
                    end
                end
                if (we) begin
                    n_we++;
                    if (outcomes.size() == 0) begin
                        chk("unexpected_we", 256'(we), 256'(0));
                    end else begin
                        o = outcomes.pop_front();
                        chk("we_outcome_is_line", 256'(o.is_err), 256'(0));
                        chk("line_data", wr_data, o.line);
                    end
                end
                if (refill_err) begin
                    if (outcomes.size() == 0) begin
                        chk("unexpected_refill_err", 256'(refill_err), 256'(0));
                    end else begin
                        o = outcomes.pop_front();
                        chk("err_outcome_is_abort", 256'(o.is_err), 256'(1));
                        chk("partial_line_kept", wr_data, o.line);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int ca, cb, n, we0, cnt;
        bit found;

        // Reset values
        #12;
        check_all_zero("reset_held");
        chk("wb_sel_const", 256'(wb.wb_sel_o), 256'(4'hF));
        chk("wb_we_const", 256'(wb.wb_we_o), 256'(0));
        chk("wb_bte_const", 256'(wb.wb_bte_o), 256'(0));
        chk("wb_dat_o_const", 256'(wb.wb_dat_o), 256'(0));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("after_release");

        // Zero-wait refill at 0x1234, data A0+k
        run_txn(32'h0000_1234, 1'b0, 32'hA0, 0, 0, -1, -1, 1'b0);
        chk("line_word0", 256'(wr_data[31:0]), 256'(32'hA0));
        chk("line_word7", 256'(wr_data[255:224]), 256'(32'hA7));

        // Ack every other cycle, retry on beat 3
        run_txn(32'h0000_5A40, 1'b1, 32'h0, 1, 1, 3, -1, 1'b0);

        // Error together with ack on beat 5
        run_txn(32'h0001_0000, 1'b1, 32'h0, 0, 0, -1, 5, 1'b1);

        // Reset asserted between edges on beat 4
        queue_txn(32'h0002_0060, 1'b1, 32'h0, 0, 0, -1, -1, 1'b0, ca);
        @(posedge clk); #1;
        miss_req = 1'b1; miss_addr = 32'h0002_0060;
        @(posedge clk); #1;
        miss_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wb.wb_stb_o && wb.wb_adr_o == 32'h0002_0070) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("reset_test_reached_beat4", 256'(found), 256'(1));
        #2;
        rst_n = 1'b1;
        #1;
        check_all_zero("async_reset");
        flush_model();
        #20;
        rst_n = 1'b0;
        run_txn(32'h0003_0000, 1'b1, 32'h0, 0, 1, -1, -1, 1'b0);

        // Miss while busy is ignored, then back-to-back refill
        we0 = n_we;
        queue_txn(32'h0004_0100, 1'b1, 32'h0, 1, 1, -1, -1, 1'b0, ca);
        queue_txn(32'h0004_0200, 1'b1, 32'h0, 0, 1, -1, -1, 1'b0, cb);
        @(posedge clk); #1;
        miss_req = 1'b1; miss_addr = 32'h0004_0100;
        @(posedge clk); #1;
        miss_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        miss_req = 1'b1; miss_addr = 32'hDEAD_BEE0;
        @(posedge clk); #1;
        miss_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (we) begin found = 1'b1; break; end
        end
        chk("b2b_first_we_seen", 256'(found), 256'(1));
        miss_req = 1'b1; miss_addr = 32'h0004_0200;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (wb.wb_cyc_o) begin n = i; break; end
        end
        chk("b2b_restart_edges_after_we", 256'(n), 256'(3));
        miss_req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!freeze) break;
        end
        @(negedge clk);
        chk("b2b_we_pulses", 256'(n_we - we0), 256'(2));

        // Randomized refills
        for (int t = 0; t < 30; t++) begin
            int mw, rb, eb;
            mw = $urandom_range(2, 0);
            rb = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            eb = ($urandom_range(7, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            run_txn($urandom, 1'b1, 32'h0, 0, mw, rb, eb, 1'($urandom_range(1, 0)));
        end

        // Silent slave
`ifdef ICACHE_REFILL_TIMEOUT_EN
        begin
            out_t o;
            o.is_err = 1'b1; o.line = model_line;
            outcomes.push_back(o);
        end
        @(posedge clk); #1;
        miss_req = 1'b1; miss_addr = 32'h0005_0000;
        @(posedge clk); #1;
        miss_req = 1'b0;
        cnt = 0; found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!wb.wb_cyc_o) begin found = refill_err; break; end
            cnt++;
        end
        chk("timeout_cyc_cycles", 256'(cnt), 256'(TMO));
        chk("timeout_refill_err", 256'(found), 256'(1));
        @(negedge clk);
        chk("timeout_err_one_cycle", 256'(refill_err), 256'(0));
`else
        @(posedge clk); #1;
        miss_req = 1'b1; miss_addr = 32'h0005_0000;
        @(posedge clk); #1;
        miss_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (wb.wb_cyc_o && freeze) cnt++;
        end
        chk("no_timeout_cyc_held", 256'(cnt), 256'(1000));
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        check_all_zero("reset_after_hang");
        flush_model();
        #20;
        rst_n = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("beats_left", 256'(exp_beats.size()), 256'(0));
        chk("outcomes_left", 256'(outcomes.size()), 256'(0));
        chk("responses_left", 256'(plan.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
